// File: rtl/load_align_unit_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types
//
// Shared RV32I types used by the load path:
//   rv32i_word          - 32-bit architectural data word
//   load_funct3_t       - funct3 encodings of the RV32I load instructions
//   load_align_state_t  - state encoding for load_align_unit
//
// Also holds helper functions that classify a load by its funct3.
// ----------------------------------------------------------------------------
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } load_align_state_t;

    // True only for the five encodings that name a real RV32I load.
    function automatic logic isLegalLoad(input logic [2:0] funct3);
        logic legal;
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Access size in bytes; illegal encodings report zero.
    function automatic logic [2:0] loadSize(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            3'b000, 3'b100: size = 3'd1;
            3'b001, 3'b101: size = 3'd2;
            3'b010:         size = 3'd4;
            default:        size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// ----------------------------------------------------------------------------
// load_extract
//
// Purely combinational data path of the load alignment unit. The two memory
// beats are concatenated into one double-width window, the requested bytes
// are selected starting at the byte offset, and the result is sign- or
// zero-extended according to the load type.
//
// Ports:
//   i_lo      - first (lower-address) bus beat
//   i_hi      - second beat, zero when the load fits in one beat
//   i_offset  - byte offset of the load inside the first beat
//   i_funct3  - load type
//   o_data    - aligned, extended 32-bit result
// ----------------------------------------------------------------------------
module load_extract
    import rv32i_types::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]             i_lo,
    input  logic [DATA_WIDTH-1:0]             i_hi,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   i_offset,
    input  load_funct3_t                      i_funct3,
    output rv32i_word                         o_data
);

    logic [2*DATA_WIDTH-1:0] w_merged;
    rv32i_word               w_word;

    // The high beat sits above the low beat, so a right shift by the byte
    // offset lines the addressed byte up with bit 0 even when the access
    // runs past the end of the low beat. The largest offset still leaves
    // 32 bits inside the window, so the part select never runs off the top.
    assign w_merged = {i_hi, i_lo};
    assign w_word   = w_merged[{i_offset, 3'b000} +: 32];

    // Extension to a full register word.
    always_comb begin
        o_data = '0;
        case (i_funct3)
            lb:      o_data = {{24{w_word[7]}}, w_word[7:0]};
            lbu:     o_data = {24'd0, w_word[7:0]};
            lh:      o_data = {{16{w_word[15]}}, w_word[15:0]};
            lhu:     o_data = {16'd0, w_word[15:0]};
            lw:      o_data = w_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// ----------------------------------------------------------------------------
// load_align_unit
//
// Multi-cycle load alignment between the MEM stage and the data memory port.
// A request is latched, one or two bus-word-aligned reads are issued, the
// beats are merged and the addressed bytes are extracted and extended.
//
// Optional feature macro: LOAD_ALIGN_SPLIT_EN
//   defined   - loads crossing a bus word are split into two reads
//   undefined - crossing loads finish immediately with resp_err set and
//               never touch memory
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   req_valid     - load request present
//   req_ready     - unit idle; request taken when req_valid && req_ready
//   req_addr      - byte address of the load
//   req_funct3    - load type
//   resp_valid    - one-cycle result strobe
//   resp_data     - aligned, extended load data (zero on error)
//   resp_err      - illegal funct3 or unsupported crossing access
//   mem_read      - memory read strobe, held until mem_resp
//   mem_address   - bus-word-aligned read address
//   mem_rdata     - read data, sampled with mem_resp
//   mem_resp      - read complete
// ----------------------------------------------------------------------------
module load_align_unit
    import rv32i_types::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  load_funct3_t          req_funct3,
    output logic                  resp_valid,
    output rv32i_word             resp_data,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int OFF_WIDTH  = $clog2(BYTES);

    load_align_state_t      r_state;
    load_align_state_t      w_nextState;

    logic [ADDR_WIDTH-1:0]  r_addr;
    load_funct3_t           r_funct3;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_lo;
    logic [DATA_WIDTH-1:0]  w_hi;

    logic [OFF_WIDTH-1:0]   w_reqOffset;
    logic                   w_reqLegal;
    logic                   w_reqCross;
    logic                   w_reqReject;
    logic                   w_accept;
    logic [ADDR_WIDTH-1:0]  w_baseAddr;
    rv32i_word              w_extracted;

    // Classify the incoming request: legal encoding and whether the bytes
    // run past the end of the first bus word.
    assign w_reqOffset = req_addr[OFF_WIDTH-1:0];
    assign w_reqLegal  = isLegalLoad(req_funct3);
    assign w_reqCross  = (int'(w_reqOffset) + int'(loadSize(req_funct3))) > BYTES;
    assign w_accept    = (r_state == IDLE) && req_valid;

`ifdef LOAD_ALIGN_SPLIT_EN
    logic                   r_cross;
    logic [DATA_WIDTH-1:0]  r_hi;

    assign w_reqReject = 1'b0;
    assign w_hi        = r_hi;

    // Second-beat bookkeeping. The high beat is cleared on accept so a
    // single-beat load always merges against zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cross <= 1'b0;
            r_hi    <= '0;
        end else begin
            if (w_accept) begin
                r_cross <= w_reqCross;
                r_hi    <= '0;
            end
            if ((r_state == RD1) && mem_resp) begin
                r_hi <= mem_rdata;
            end
        end
    end
`else
    assign w_reqReject = w_reqCross;
    assign w_hi        = '0;
`endif

    // Request latch, error flag and first-beat capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_funct3 <= lb;
            r_err    <= 1'b0;
            r_lo     <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_err    <= !w_reqLegal || w_reqReject;
            end
            if ((r_state == RD0) && mem_resp) begin
                r_lo <= mem_rdata;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_baseAddr = {r_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};

    // Next state and state-decoded outputs. Rejected requests skip memory
    // entirely and go straight to DONE so the error is reported one cycle
    // after acceptance.
    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!w_reqLegal || w_reqReject) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = RD0;
                    end
                end
            end
            RD0: begin
                mem_read    = 1'b1;
                mem_address = w_baseAddr;
                if (mem_resp) begin
`ifdef LOAD_ALIGN_SPLIT_EN
                    w_nextState = r_cross ? RD1 : DONE;
`else
                    w_nextState = DONE;
`endif
                end
            end
            RD1: begin
`ifdef LOAD_ALIGN_SPLIT_EN
                mem_read    = 1'b1;
                mem_address = w_baseAddr + ADDR_WIDTH'(BYTES);
                if (mem_resp) begin
                    w_nextState = DONE;
                end
`else
                w_nextState = IDLE;
`endif
            end
            DONE: begin
                resp_valid  = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extract (
        .i_lo     (r_lo),
        .i_hi     (w_hi),
        .i_offset (r_addr[OFF_WIDTH-1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_extracted)
    );

    // Response data is forced to zero outside DONE and on error so the
    // consumer never sees stale beats.
    assign resp_err  = resp_valid && r_err;
    assign resp_data = (resp_valid && !r_err) ? w_extracted : '0;

endmodule

// File: tb/tb_load_align_unit.sv
// ----------------------------------------------------------------------------
// tb_load_align_unit
//
// Directed bench for load_align_unit. A 32-bit and a 64-bit bus instance
// share the request and memory stimulus; selWide picks which one is driven
// and observed. Expected results are hand-computed per vector, with the
// crossing cases depending on LOAD_ALIGN_SPLIT_EN.
// ----------------------------------------------------------------------------
module tb_load_align_unit;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         reqValid;
    logic [31:0]  reqAddr;
    load_funct3_t reqFunct3;
    logic         memResp;
    logic [63:0]  memRdata;
    bit           selWide;

    logic         n32Ready, n32RespValid, n32RespErr, n32MemRead;
    logic [31:0]  n32RespData, n32MemAddr;
    logic         n64Ready, n64RespValid, n64RespErr, n64MemRead;
    logic [31:0]  n64RespData, n64MemAddr;

    logic         obsReady, obsRespValid, obsRespErr, obsMemRead;
    logic [31:0]  obsRespData, obsMemAddr;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (reqValid && !selWide),
        .req_ready   (n32Ready),
        .req_addr    (reqAddr),
        .req_funct3  (reqFunct3),
        .resp_valid  (n32RespValid),
        .resp_data   (n32RespData),
        .resp_err    (n32RespErr),
        .mem_read    (n32MemRead),
        .mem_address (n32MemAddr),
        .mem_rdata   (memRdata[31:0]),
        .mem_resp    (memResp && !selWide)
    );

    load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (reqValid && selWide),
        .req_ready   (n64Ready),
        .req_addr    (reqAddr),
        .req_funct3  (reqFunct3),
        .resp_valid  (n64RespValid),
        .resp_data   (n64RespData),
        .resp_err    (n64RespErr),
        .mem_read    (n64MemRead),
        .mem_address (n64MemAddr),
        .mem_rdata   (memRdata),
        .mem_resp    (memResp && selWide)
    );

    assign obsReady     = selWide ? n64Ready     : n32Ready;
    assign obsRespValid = selWide ? n64RespValid : n32RespValid;
    assign obsRespErr   = selWide ? n64RespErr   : n32RespErr;
    assign obsRespData  = selWide ? n64RespData  : n32RespData;
    assign obsMemRead   = selWide ? n64MemRead   : n32MemRead;
    assign obsMemAddr   = selWide ? n64MemAddr   : n32MemAddr;

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one load on the selected instance at a negedge and plays the
    // memory side: each beat is answered after 'waits' stall cycles. Checks
    // read addresses, number of beats, response data/error and latency in
    // cycles counted from the accepting edge.
    task automatic applyStimulus(input bit wide, input string tag,
                                 input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [63:0] beat0, input logic [63:0] beat1,
                                 input int waits,
                                 input logic [31:0] expData, input logic expErr,
                                 input logic [31:0] expAddr0, input logic [31:0] expAddr1,
                                 input int expBeats, input int expLat);
        int cyc;
        int beats;
        int waitCnt;
        int lat;
        int firstRead;
        bit done;
        selWide = wide;
        checkOutput({tag, ".ready"}, obsReady, 1);
        reqValid  = 1'b1;
        reqAddr   = addr;
        reqFunct3 = load_funct3_t'(f3);
        @(negedge clk);
        reqValid  = 1'b0;
        cyc       = 1;
        beats     = 0;
        waitCnt   = 0;
        lat       = -1;
        firstRead = -1;
        done      = 1'b0;
        while (!done && cyc < 40) begin
            memResp = 1'b0;
            if (obsRespValid) begin
                lat  = cyc;
                done = 1'b1;
                checkOutput({tag, ".data"},  obsRespData, expData);
                checkOutput({tag, ".err"},   obsRespErr, expErr);
                checkOutput({tag, ".busy"},  obsReady, 0);
                checkOutput({tag, ".beats"}, beats, expBeats);
            end else if (obsMemRead) begin
                if (firstRead < 0) firstRead = cyc;
                checkOutput({tag, (beats == 0) ? ".addr0" : ".addr1"}, obsMemAddr,
                            (beats == 0) ? expAddr0 : expAddr1);
                if (waitCnt == waits) begin
                    memResp  = 1'b1;
                    memRdata = (beats == 0) ? beat0 : beat1;
                    beats++;
                    waitCnt  = 0;
                end else begin
                    waitCnt++;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        memResp = 1'b0;
        checkOutput({tag, ".latency"}, lat, expLat);
        if (expBeats > 0) begin
            checkOutput({tag, ".firstRead"}, firstRead, 1);
        end
        @(negedge clk);
    endtask

    // Starts a 32-bit load, optionally answers the first beat so the unit
    // sits in RD1, then resets it while a read is outstanding. Afterwards a
    // stray mem_resp must not produce a response.
    task automatic resetMidLoad(input string tag, input logic [31:0] addr,
                                input bit toRd1, input logic [31:0] expStallAddr);
        selWide   = 1'b0;
        reqValid  = 1'b1;
        reqAddr   = addr;
        reqFunct3 = lw;
        @(negedge clk);
        reqValid  = 1'b0;
        checkOutput({tag, ".readRd0"}, obsMemRead, 1);
        if (toRd1) begin
            memResp  = 1'b1;
            memRdata = 64'h0000_0000_AABB_CCDD;
            @(negedge clk);
            memResp  = 1'b0;
            checkOutput({tag, ".readRd1"}, obsMemRead, 1);
        end
        checkOutput({tag, ".stallAddr"}, obsMemAddr, expStallAddr);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput({tag, ".rstRead"},  obsMemRead, 0);
        checkOutput({tag, ".rstReady"}, obsReady, 1);
        checkOutput({tag, ".rstResp"},  obsRespValid, 0);
        memResp  = 1'b1;
        memRdata = 64'h0000_0000_1122_3344;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput({tag, ".strayResp"}, obsRespValid, 0);
            checkOutput({tag, ".strayRead"}, obsMemRead, 0);
        end
        memResp = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        reqValid  = 1'b0;
        reqAddr   = '0;
        reqFunct3 = lb;
        memResp   = 1'b0;
        memRdata  = '0;
        selWide   = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state of the 32-bit instance.
        checkOutput("reset.ready",     obsReady, 1);
        checkOutput("reset.respValid", obsRespValid, 0);
        checkOutput("reset.respErr",   obsRespErr, 0);
        checkOutput("reset.respData",  obsRespData, 0);
        checkOutput("reset.memRead",   obsMemRead, 0);
        checkOutput("reset.memAddr",   obsMemAddr, 0);
        rst = 1'b0;
        @(negedge clk);

        // 32-bit single-beat loads.
        applyStimulus(0, "lbu1003", 32'h0000_1003, 3'b100, 64'h80FF_1234, 64'h0, 0,
                      32'h0000_0080, 0, 32'h0000_1000, 32'h0, 1, 2);
        applyStimulus(0, "lb1003",  32'h0000_1003, 3'b000, 64'h80FF_1234, 64'h0, 0,
                      32'hFFFF_FF80, 0, 32'h0000_1000, 32'h0, 1, 2);
        applyStimulus(0, "lhu1002", 32'h0000_1002, 3'b101, 64'h8765_4321, 64'h0, 0,
                      32'h0000_8765, 0, 32'h0000_1000, 32'h0, 1, 2);
        applyStimulus(0, "lh1001",  32'h0000_1001, 3'b001, 64'h0080_FF00, 64'h0, 0,
                      32'hFFFF_80FF, 0, 32'h0000_1000, 32'h0, 1, 2);
        applyStimulus(0, "lwWait",  32'h0000_1004, 3'b010, 64'hDEAD_BEEF, 64'h0, 2,
                      32'hDEAD_BEEF, 0, 32'h0000_1004, 32'h0, 1, 4);
        applyStimulus(0, "illegal", 32'h0000_1000, 3'b011, 64'h0, 64'h0, 0,
                      32'h0, 1, 32'h0, 32'h0, 0, 1);

        // 64-bit single-beat loads.
        applyStimulus(1, "w64lh",  32'h0000_2006, 3'b001, 64'h8001_0000_0000_0000, 64'h0, 0,
                      32'hFFFF_8001, 0, 32'h0000_2000, 32'h0, 1, 2);
        applyStimulus(1, "w64lw",  32'h0000_2004, 3'b010, 64'h1234_5678_0000_0000, 64'h0, 0,
                      32'h1234_5678, 0, 32'h0000_2000, 32'h0, 1, 2);
        applyStimulus(1, "w64lbu", 32'h0000_2007, 3'b100, 64'hF000_0000_0000_0000, 64'h0, 0,
                      32'h0000_00F0, 0, 32'h0000_2000, 32'h0, 1, 2);

`ifdef LOAD_ALIGN_SPLIT_EN
        // Crossing loads merged from two beats.
        applyStimulus(0, "lwSplit", 32'h0000_1002, 3'b010, 64'hAABB_CCDD, 64'h1122_3344, 0,
                      32'h3344_AABB, 0, 32'h0000_1000, 32'h0000_1004, 2, 3);
        applyStimulus(0, "lhWrap",  32'hFFFF_FFFF, 3'b001, 64'hAB00_0000, 64'h0000_00CD, 0,
                      32'hFFFF_CDAB, 0, 32'hFFFF_FFFC, 32'h0000_0000, 2, 3);
        applyStimulus(0, "lhSplit", 32'h0000_1003, 3'b001, 64'h7F00_0000, 64'h0000_0012, 1,
                      32'h0000_127F, 0, 32'h0000_1000, 32'h0000_1004, 2, 5);
        applyStimulus(1, "w64lwSplit", 32'h0000_2006, 3'b010, 64'hBBAA_0000_0000_0000,
                      64'h0000_0000_0000_DDCC, 0,
                      32'hDDCC_BBAA, 0, 32'h0000_2000, 32'h0000_2008, 2, 3);
        resetMidLoad("rstRd1", 32'h0000_1002, 1'b1, 32'h0000_1004);
`else
        // Crossing loads rejected without touching memory.
        applyStimulus(0, "lwSplit", 32'h0000_1002, 3'b010, 64'hAABB_CCDD, 64'h1122_3344, 0,
                      32'h0, 1, 32'h0, 32'h0, 0, 1);
        applyStimulus(0, "lhWrap",  32'hFFFF_FFFF, 3'b001, 64'hAB00_0000, 64'h0000_00CD, 0,
                      32'h0, 1, 32'h0, 32'h0, 0, 1);
        applyStimulus(0, "lhSplit", 32'h0000_1003, 3'b001, 64'h7F00_0000, 64'h0000_0012, 1,
                      32'h0, 1, 32'h0, 32'h0, 0, 1);
        applyStimulus(1, "w64lwSplit", 32'h0000_2006, 3'b010, 64'hBBAA_0000_0000_0000,
                      64'h0000_0000_0000_DDCC, 0,
                      32'h0, 1, 32'h0, 32'h0, 0, 1);
`endif

        // Reset while the first read is still outstanding.
        resetMidLoad("rstRd0", 32'h0000_1000, 1'b0, 32'h0000_1000);

        // Unit must be usable again after the abort.
        applyStimulus(0, "postRst", 32'h0000_1008, 3'b010, 64'hCAFE_F00D, 64'h0, 0,
                      32'hCAFE_F00D, 0, 32'h0000_1008, 32'h0, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Multi-cycle load alignment unit sitting between the MEM stage and the data memory port. Accepts one load request (byte address and `load_funct3_t`), issues one or two word-aligned memory reads, merges the beats, then byte-selects and sign/zero-extends the result to a 32-bit `rv32i_word`. Generalises single-word alignment to a parametrised bus width and to loads that straddle a bus-word boundary.

## Interface
Parameters:
- `DATA_WIDTH`, 32: memory bus width in bits; legal values 32 and 64.
- `ADDR_WIDTH`, 32: byte address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: load request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid && req_ready`.
- `req_addr` in `ADDR_WIDTH`: byte address of the load.
- `req_funct3` in `load_funct3_t`: lb, lh, lw, lbu, lhu.
- `resp_valid` out 1: one-cycle pulse; result valid.
- `resp_data` out 32: aligned, extended load data.
- `resp_err` out 1: qualifies `resp_valid`; illegal funct3 or unsupported misaligned access.
- `mem_read` out 1: memory read strobe; held until `mem_resp`.
- `mem_address` out `ADDR_WIDTH`: bus-word-aligned address (low log2(DATA_WIDTH/8) bits zero).
- `mem_rdata` in `DATA_WIDTH`: read data, sampled when `mem_resp`.
- `mem_resp` in 1: read complete.

## Operation
- B = DATA_WIDTH/8; offset o = `req_addr[log2(B)-1:0]`; size s = 1 (lb/lbu), 2 (lh/lhu), 4 (lw). Crossing = o + s > B.
- States: IDLE, RD0, RD1, DONE.
- IDLE: `req_ready`=1. On accept, latch address and funct3. Illegal funct3 -> DONE with error. Crossing with split disabled -> DONE with error. Otherwise -> RD0.
- RD0: `mem_read`=1, `mem_address` = latched address with low bits cleared. On `mem_resp`, capture `mem_rdata` as lo beat; crossing -> RD1, else -> DONE.
- RD1: `mem_read`=1, `mem_address` = RD0 address + B, modulo 2^ADDR_WIDTH (0xFFFF_FFFC + 4 -> 0x0000_0000). On `mem_resp`, capture hi beat -> DONE.
- DONE: `resp_valid`=1 for one cycle -> IDLE. Merge {hi, lo} (hi = 0 if single beat), shift right by 8·o, take low 32 bits, extend: lb sext8, lbu zext8, lh sext16, lhu zext16, lw pass. On error, `resp_data`=0, `resp_err`=1.
- `mem_resp` in IDLE or DONE is ignored.

## Timing
- All outputs decoded from registered state and latched data; no input-to-output combinational path except none.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_data`=0, `mem_read`=0, `mem_address`=0.
- Accept at edge T: single beat with zero-wait memory -> `mem_read` in cycle T+1, `resp_valid` in T+2. Split -> `resp_valid` in T+3. Each memory wait cycle adds one.
- Error path: `resp_valid` in cycle T+1, `mem_read` never asserted.
- `req_ready`=0 in RD0, RD1, DONE; no back-to-back accept in DONE cycle (next accept earliest the cycle after `resp_valid`).
- `rst` mid-operation: after the reset edge state is IDLE, `mem_read`=0, no `resp_valid` for the aborted load; late `mem_resp` ignored.

## Configuration
- `LOAD_ALIGN_SPLIT_EN` defined: crossing loads split into RD0+RD1 and merged.
- Undefined: RD1 not built; crossing loads complete via error path (`resp_err`=1, `resp_data`=0, no memory access). Non-crossing behaviour identical.

## Structure
- `rv32i_types`: existing `load_funct3_t`; add `load_align_state_t` enum (IDLE, RD0, RD1, DONE).
- Sub-module `load_extract`: combinational merge/shift/extend, parametrised by `DATA_WIDTH`; FSM and beat registers in `load_align_unit`.

## Test plan
- DATA_WIDTH=32, lbu 0x0000_1003, `mem_rdata`=0x80FF_1234 -> `mem_address`=0x1000, `resp_data`=0x0000_0080, one beat, `resp_valid` at T+2.
- Same with lb -> `resp_data`=0xFFFF_FF80.
- Split enabled, lw 0x0000_1002, beats 0xAABB_CCDD @0x1000 then 0x1122_3344 @0x1004 -> `resp_data`=0x3344_AABB, `resp_err`=0, `resp_valid` at T+3.
- Split disabled, same lw -> `mem_read` never high, `resp_err`=1, `resp_data`=0 at T+1; lh 0xFFFF_FFFF with split enabled -> second beat at 0x0000_0000.
- DATA_WIDTH=64, lh 0x0000_2006, `mem_rdata`=0x8001_0000_0000_0000 -> `mem_address`=0x2000, single beat, `resp_data`=0xFFFF_8001.
- `rst` asserted in RD1 with `mem_resp` low -> next cycle `mem_read`=0, `req_ready`=1; subsequent stray `mem_resp` produces no `resp_valid`.
